// File: rtl/processor_controller.sv
// rtl/processor_controller.sv - multi-cycle control FSM for the 16-bit processor datapath
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   I_data              instruction ROM read data, valid the cycle after I_rd
//   PC_addr, I_rd       instruction ROM address / read enable
//   D_addr, D_wr        data memory address / write enable
//   RF_s                write-back select: 0 = ALU result, 1 = data memory read data
//   W_addr, W_en        register file write address / enable
//   Ra_addr, Rb_addr    register file read port addresses
//   ALU_op              0 = pass A, 1 = A+B, 2 = A-B
//   state_dbg, halted   current state encoding / HALT indicator
module processor_controller #(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        I_data,
  output logic [PC_W-1:0]    PC_addr,
  output logic               I_rd,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_wr,
  output logic               RF_s,
  output logic [RADDR_W-1:0] W_addr,
  output logic               W_en,
  output logic [RADDR_W-1:0] Ra_addr,
  output logic [RADDR_W-1:0] Rb_addr,
  output logic [2:0]         ALU_op,
  output logic [3:0]         state_dbg,
  output logic               halted
);

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_LOAD_IR = 4'd2,
    S_DECODE  = 4'd3,
    S_LOAD_A  = 4'd4,
    S_LOAD_B  = 4'd5,
    S_STORE_A = 4'd6,
    S_STORE_B = 4'd7,
    S_ADD_A   = 4'd8,
    S_ADD_B   = 4'd9,
    S_SUB_A   = 4'd10,
    S_SUB_B   = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  state_t               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [15:0]          ir_q;
  logic                 i_rd_q;
  logic [DADDR_W-1:0]   d_addr_q;
  logic                 d_wr_q;
  logic                 rf_s_q;
  logic [RADDR_W-1:0]   w_addr_q;
  logic                 w_en_q;
  logic [RADDR_W-1:0]   ra_addr_q;
  logic [RADDR_W-1:0]   rb_addr_q;
  logic [2:0]           alu_op_q;
  logic                 halted_q;
  logic [PC_W-1:0]      pc_d;

  assign pc_d = pc_q + PC_W'(1);

  // Outputs are registered: each transition loads the values that the
  // destination state presents, so every output is valid for the whole
  // cycle of its state. Addresses are only loaded on entry to their
  // defining state and otherwise keep their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      pc_q      <= '0;
      ir_q      <= '0;
      i_rd_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wr_q    <= 1'b0;
      rf_s_q    <= 1'b0;
      w_addr_q  <= '0;
      w_en_q    <= 1'b0;
      ra_addr_q <= '0;
      rb_addr_q <= '0;
      alu_op_q  <= 3'd0;
      halted_q  <= 1'b0;
    end else begin
      // Enables are single-cycle pulses; only the transition that enters
      // their state raises them.
      i_rd_q <= 1'b0;
      w_en_q <= 1'b0;
      d_wr_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          state_q <= S_FETCH;
          i_rd_q  <= 1'b1;
        end
        S_FETCH: begin
          state_q <= S_LOAD_IR;
        end
        S_LOAD_IR: begin
          // ROM data is valid here, one cycle after the FETCH read.
          ir_q    <= I_data;
          pc_q    <= pc_d;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (ir_q[15:12])
            4'd1: begin
              state_q  <= S_LOAD_A;
              d_addr_q <= DADDR_W'(ir_q[11:4]);
              rf_s_q   <= 1'b1;
            end
            4'd2: begin
              state_q   <= S_STORE_A;
              ra_addr_q <= RADDR_W'(ir_q[11:8]);
              d_addr_q  <= DADDR_W'(ir_q[7:0]);
            end
            4'd3: begin
              state_q   <= S_ADD_A;
              ra_addr_q <= RADDR_W'(ir_q[11:8]);
              rb_addr_q <= RADDR_W'(ir_q[7:4]);
              alu_op_q  <= 3'd1;
            end
            4'd4: begin
              state_q   <= S_SUB_A;
              ra_addr_q <= RADDR_W'(ir_q[11:8]);
              rb_addr_q <= RADDR_W'(ir_q[7:4]);
              alu_op_q  <= 3'd2;
            end
            4'd5: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: begin
              // NOOP and unassigned opcodes go straight back to fetch.
              state_q <= S_FETCH;
              i_rd_q  <= 1'b1;
            end
          endcase
        end
        S_LOAD_A: begin
          // Data memory read issued in LOAD_A returns in LOAD_B.
          state_q  <= S_LOAD_B;
          w_addr_q <= RADDR_W'(ir_q[3:0]);
          w_en_q   <= 1'b1;
        end
        S_LOAD_B: begin
          state_q <= S_FETCH;
          i_rd_q  <= 1'b1;
          rf_s_q  <= 1'b0;
        end
        S_STORE_A: begin
          // Register read issued in STORE_A supplies write data in STORE_B.
          state_q <= S_STORE_B;
          d_wr_q  <= 1'b1;
        end
        S_STORE_B: begin
          state_q <= S_FETCH;
          i_rd_q  <= 1'b1;
        end
        S_ADD_A, S_SUB_A: begin
          state_q  <= (state_q == S_ADD_A) ? S_ADD_B : S_SUB_B;
          w_addr_q <= RADDR_W'(ir_q[3:0]);
          w_en_q   <= 1'b1;
          rf_s_q   <= 1'b0;
        end
        S_ADD_B, S_SUB_B: begin
          state_q <= S_FETCH;
          i_rd_q  <= 1'b1;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign PC_addr   = pc_q;
  assign I_rd      = i_rd_q;
  assign D_addr    = d_addr_q;
  assign D_wr      = d_wr_q;
  assign RF_s      = rf_s_q;
  assign W_addr    = w_addr_q;
  assign W_en      = w_en_q;
  assign Ra_addr   = ra_addr_q;
  assign Rb_addr   = rb_addr_q;
  assign ALU_op    = alu_op_q;
  assign state_dbg = state_q;
  assign halted    = halted_q;

endmodule
